// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM pipeline register and a doubleword-wide
// data memory. Sub-doubleword stores are read-modify-write; loads are lane
// extracted and sign/zero extended; misaligned requests fault without a strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; misaligned faults answer from here
// RD    | memory read strobe for a load or a partial store
// EXT   | read data back: extend a load, or merge a partial store
// WR    | memory write strobe with the buffered doubleword
module mem_access_unit #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read_en,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, EXT, WR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              write_q, write_d;
   logic              unsigned_q, unsigned_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] wbuf_q, wbuf_d;
   logic              resp_valid_q, resp_valid_d;
   logic              misalign_q, misalign_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic              req_misalign;
   logic [5:0]        shamt;
   logic [DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0] wd_shift;
   logic [7:0]        size_mask;
   logic [7:0]        lane_mask;
   logic              sign_en;
   logic [DATA_W-1:0] ext_data;
   logic [DATA_W-1:0] merged;

   // Alignment check on the incoming request (byte accesses never fault)
   always_comb begin
      req_misalign = 1'b0;
      case (req_size)
         2'b00:   req_misalign = 1'b0;
         2'b01:   req_misalign = req_addr[0];
         2'b10:   req_misalign = |req_addr[1:0];
         default: req_misalign = |req_addr[2:0];
      endcase
   end

   assign shamt    = {addr_q[2:0], 3'b000};
   assign rd_shift = mem_rdata >> shamt;
   assign wd_shift = wdata_q << shamt;
   assign sign_en  = ~unsigned_q;

   // Lane extraction with sign/zero extension, and the store merge mask
   always_comb begin
      ext_data  = rd_shift;
      size_mask = 8'hFF;
      case (size_q)
         2'b00: begin
            ext_data  = {{56{sign_en & rd_shift[7]}}, rd_shift[7:0]};
            size_mask = 8'h01;
         end
         2'b01: begin
            ext_data  = {{48{sign_en & rd_shift[15]}}, rd_shift[15:0]};
            size_mask = 8'h03;
         end
         2'b10: begin
            ext_data  = {{32{sign_en & rd_shift[31]}}, rd_shift[31:0]};
            size_mask = 8'h0F;
         end
         default: begin
            ext_data  = rd_shift;
            size_mask = 8'hFF;
         end
      endcase
      lane_mask = size_mask << addr_q[2:0];
   end

   // Replace the selected byte lanes of the read doubleword with store data
   always_comb begin
      merged = '0;
      for (int i = 0; i < 8; i++) begin
         merged[8*i +: 8] = lane_mask[i] ? wd_shift[8*i +: 8] : mem_rdata[8*i +: 8];
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      write_d      = write_q;
      unsigned_d   = unsigned_q;
      wdata_d      = wdata_q;
      wbuf_d       = wbuf_q;
      resp_valid_d = 1'b0;
      misalign_d   = 1'b0;
      resp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d     = req_addr;
               size_d     = req_size;
               write_d    = req_write;
               unsigned_d = req_unsigned;
               wdata_d    = req_wdata;
               if (req_misalign) begin
                  resp_valid_d = 1'b1;
                  misalign_d   = 1'b1;
               end else if (req_write && (req_size == 2'b11)) begin
                  wbuf_d  = req_wdata;
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            state_d = EXT;
         end
         EXT: begin
            if (write_q) begin
               wbuf_d  = merged;
               state_d = WR;
            end else begin
               resp_valid_d = 1'b1;
               resp_rdata_d = ext_data;
               state_d      = IDLE;
            end
         end
         WR: begin
            resp_valid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         size_q       <= '0;
         write_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         wdata_q      <= '0;
         wbuf_q       <= '0;
         resp_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         write_q      <= write_d;
         unsigned_q   <= unsigned_d;
         wdata_q      <= wdata_d;
         wbuf_q       <= wbuf_d;
         resp_valid_q <= resp_valid_d;
         misalign_q   <= misalign_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign mem_read_en  = (state_q == RD);
   assign mem_write_en = (state_q == WR);
   assign mem_wdata    = wbuf_q;
   assign mem_addr     = {3'b000, addr_q[ADDR_W-1:3]};
   assign resp_valid   = resp_valid_q;
   assign misalign     = misalign_q;
   assign resp_rdata   = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random requests, byte-level
// reference memory, scoreboards for responses, reads and writes.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        misalign;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .misalign     (misalign),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_rdata    (mem_rdata)
   );

   // Doubleword memory seen by the DUT (64 doublewords = 512 bytes)
   logic [63:0] mem [64] = '{default: 64'h0};
   always @(posedge clk) begin
      if (mem_read_en)  mem_rdata <= mem[mem_addr[5:0]];
      if (mem_write_en) mem[mem_addr[5:0]] <= mem_wdata;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [63:0] rdata; logic mis; int cyc; } resp_t;
   typedef struct { logic [63:0] idx; logic [63:0] data; int cyc; } wr_t;
   typedef struct { logic [63:0] idx; int cyc; } rd_t;
   resp_t resp_q[$];
   wr_t   wr_q[$];
   rd_t   rd_q[$];

   logic [7:0] model [512] = '{default: 8'h00};

   int n_cmp = 0;
   int n_bad = 0;
   bit busy_en = 1'b0;
   int busy_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // Issue one request; the model predicts the response, reads and writes.
   // abort: a reset will cut this access short, so only its read is expected.
   task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input bit abort, output int acc);
      int n;
      int nb;
      logic [63:0] v;
      logic [63:0] base;
      n = 0;
      acc = -1;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         fail_now("issue_timeout: req_ready stuck at 0, required 1");
         return;
      end
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      acc = cyc;
      nb = 1 << sz;
      if ((addr % nb) != 0) begin
         resp_q.push_back('{rdata: 64'h0, mis: 1'b1, cyc: acc});
         return;
      end
      if (!wr || nb < 8) rd_q.push_back('{idx: addr >> 3, cyc: acc});
      if (abort) return;
      if (!wr) begin
         v = '0;
         for (int i = 0; i < nb; i++) v |= 64'(model[addr + i]) << (8 * i);
         if (!uns && nb < 8 && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
         resp_q.push_back('{rdata: v, mis: 1'b0, cyc: acc + 2});
      end else begin
         for (int i = 0; i < nb; i++) model[addr + i] = wd[8*i +: 8];
         base = addr & ~64'd7;
         v = '0;
         for (int i = 0; i < 8; i++) v |= 64'(model[base + i]) << (8 * i);
         wr_q.push_back('{idx: addr >> 3, data: v, cyc: (nb == 8) ? acc : acc + 2});
         resp_q.push_back('{rdata: 64'h0, mis: 1'b0, cyc: (nb == 8) ? acc + 1 : acc + 3});
      end
   endtask

   // Monitor: compares every strobe and response against the queues
   initial begin
      rd_t   er;
      wr_t   ew;
      resp_t ep;
      forever begin
         @(negedge clk);
         #1;
         if (busy_en && !req_ready) busy_cnt++;
         if (mem_read_en && mem_write_en) fail_now("strobe_overlap: read and write both 1, required exclusive");
         if (mem_read_en) begin
            if (rd_q.size() == 0) fail_now("unexpected_read: mem_read_en 1, required 0");
            else begin
               er = rd_q.pop_front();
               chk("rd_addr", mem_addr, er.idx);
               chk("rd_cycle", 64'(cyc), 64'(er.cyc));
            end
         end
         if (mem_write_en) begin
            if (wr_q.size() == 0) fail_now("unexpected_write: mem_write_en 1, required 0");
            else begin
               ew = wr_q.pop_front();
               chk("wr_addr", mem_addr, ew.idx);
               chk("wr_data", mem_wdata, ew.data);
               chk("wr_cycle", 64'(cyc), 64'(ew.cyc));
            end
         end
         if (resp_valid) begin
            if (resp_q.size() == 0) fail_now("unexpected_resp: resp_valid 1, required 0");
            else begin
               ep = resp_q.pop_front();
               chk("resp_rdata", resp_rdata, ep.rdata);
               chk("resp_misalign", 64'(misalign), 64'(ep.mis));
               chk("resp_cycle", 64'(cyc), 64'(ep.cyc));
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((resp_q.size() + wr_q.size() + rd_q.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if ((resp_q.size() + wr_q.size() + rd_q.size()) != 0)
         fail_now("drain_timeout: expected DUT activity never appeared");
   endtask

   initial begin
      int acc;
      int prev;
      logic [63:0] a;
      logic [63:0] v;

      #1;
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_misalign", 64'(misalign), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_rd_en", 64'(mem_read_en), 64'd0);
      chk("rst_wr_en", 64'(mem_write_en), 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1'b1, 2'b11, 1'b0, 64'h40, 64'h1122334455667788, 1'b0, acc);
      issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 1'b0, acc);
      issue(1'b1, 2'b00, 1'b0, 64'h43, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, acc);
      issue(1'b0, 2'b00, 1'b0, 64'h43, 64'h0, 1'b0, acc);
      issue(1'b0, 2'b00, 1'b1, 64'h43, 64'h0, 1'b0, acc);
      issue(1'b1, 2'b10, 1'b0, 64'h40, 64'h80000000, 1'b0, acc);
      issue(1'b0, 2'b10, 1'b0, 64'h40, 64'h0, 1'b0, acc);
      issue(1'b0, 2'b10, 1'b1, 64'h40, 64'h0, 1'b0, acc);
      issue(1'b0, 2'b10, 1'b0, 64'h44, 64'h0, 1'b0, acc);
      issue(1'b0, 2'b01, 1'b0, 64'h41, 64'h0, 1'b0, acc);
      issue(1'b1, 2'b10, 1'b0, 64'h42, 64'hDEADBEEF, 1'b0, acc);
      drain();

      // Back-to-back byte loads: no idle gap, two busy cycles each
      busy_cnt = 0;
      busy_en = 1'b1;
      prev = -1;
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 2'b00, 1'(i % 2), 64'h40 + 64'(i), 64'h0, 1'b0, acc);
         if (prev >= 0) chk("b2b_gap", 64'(acc - prev), 64'd3);
         prev = acc;
      end
      drain();
      busy_en = 1'b0;
      chk("b2b_busy_cycles", 64'(busy_cnt), 64'd16);

      // Reset while a byte store sits in EXT: no write, no response
      issue(1'b1, 2'b00, 1'b0, 64'h45, 64'hCD, 1'b1, acc);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("abort_ready", 64'(req_ready), 64'd1);
      chk("abort_wr_en", 64'(mem_write_en), 64'd0);
      chk("abort_resp_valid", 64'(resp_valid), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1'b0, 2'b00, 1'b1, 64'h45, 64'h0, 1'b0, acc);
      drain();

      // Random traffic with occasional idle cycles
      for (int i = 0; i < 300; i++) begin
         a = 64'($urandom_range(0, 511));
         v = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, v, 1'b0, acc);
      end
      drain();
      repeat (3) @(negedge clk);

      for (int d = 0; d < 64; d++) begin
         v = '0;
         for (int b = 0; b < 8; b++) v |= 64'(model[8*d + b]) << (8 * b);
         chk($sformatf("final_mem[%0d]", d), mem[d], v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
